// File: rtl/codec_loopback_gain_pkg.sv
// Shared constants and types for the codec loopback gain stage.
// The optional clip counter is enabled by defining LOOPBACK_CLIP_CNT_EN.
package codec_pkg;

  localparam int DW    = 16;
  localparam int GW    = 8;
  localparam int GFRAC = 6;

  // Product width: signed sample times a zero-extended (signed) gain.
  localparam int PW = DW + GW + 1;

  localparam int L_MSB = 2*DW - 1;
  localparam int L_LSB = DW;
  localparam int R_MSB = DW - 1;
  localparam int R_LSB = 0;

  localparam int SAT_MAX = (1 << (DW-1)) - 1;
  localparam int SAT_MIN = -(1 << (DW-1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SAT  = 2'd2,
    WR   = 2'd3
  } state_t;

endpackage

// File: rtl/codec_loopback_gain_if.sv
// FIFO-side bus of the loopback gain stage: ADC FIFO read port and DAC FIFO write port.
// Handshake: adc_fifo_out is valid while !adc_fifo_empty and a word is consumed on the
// clock edge where rd_adc_fifo is high; a word is accepted by the DAC FIFO on the edge
// where wr_dac_fifo is high, which is only ever raised while !dac_fifo_full.
interface codec_loopback_gain_if #(
  parameter int DW = codec_pkg::DW
);
  logic            adc_fifo_empty;
  logic [2*DW-1:0] adc_fifo_out;
  logic            rd_adc_fifo;
  logic            dac_fifo_full;
  logic            wr_dac_fifo;
  logic [2*DW-1:0] dac_fifo_in;

  modport master (
    input  adc_fifo_empty, adc_fifo_out, dac_fifo_full,
    output rd_adc_fifo, wr_dac_fifo, dac_fifo_in
  );

  modport slave (
    output adc_fifo_empty, adc_fifo_out, dac_fifo_full,
    input  rd_adc_fifo, wr_dac_fifo, dac_fifo_in
  );
endinterface

// File: rtl/codec_loopback_gain_chan_gain_sat.sv
// One channel of the gain stage: registered signed multiply, floor shift by GFRAC,
// and clamp to the DW-bit signed range with a clip flag.
module chan_gain_sat
  import codec_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          mul_en,
  input  logic [DW-1:0] sample,
  input  logic [GW-1:0] gain,
  output logic [DW-1:0] sat_out,
  output logic          clip
);

  localparam logic signed [PW-1:0] MAX_P = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] MIN_P = PW'(SAT_MIN);

  logic signed [PW-1:0] p_d, p_q;
  logic signed [PW-1:0] s;

  always_comb begin
    p_d = p_q;
    if (mul_en) begin
      p_d = PW'($signed(sample)) * PW'($signed({1'b0, gain}));
    end
  end

  // Arithmetic shift rounds toward minus infinity, which is the intended floor.
  always_comb begin
    s = p_q >>> GFRAC;
    clip = 1'b0;
    sat_out = s[DW-1:0];
    if (s > MAX_P) begin
      sat_out = MAX_P[DW-1:0];
      clip = 1'b1;
    end else if (s < MIN_P) begin
      sat_out = MIN_P[DW-1:0];
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) p_q <= '0;
    else        p_q <= p_d;
  end

endmodule

// File: rtl/codec_loopback_gain.sv
// Line-in to headphone loopback: pops a stereo sample from the ADC FIFO, applies a
// per-channel saturating gain and pushes it to the DAC FIFO. Clip counter: LOOPBACK_CLIP_CNT_EN.
module codec_loopback_gain
  import codec_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  bypass,
  input  logic [GW-1:0]         gain_l,
  input  logic [GW-1:0]         gain_r,
  codec_loopback_gain_if.master fifo,
  output logic                  busy,
  output logic                  sample_done_tick,
  output logic [15:0]           clip_cnt,
  output state_t                state_dbg
);

  state_t          state_d, state_q;
  logic [2*DW-1:0] in_d, in_q;
  logic [GW-1:0]   gl_d, gl_q, gr_d, gr_q;
  logic [2*DW-1:0] dac_d, dac_q;
  logic            rd, wr, mul_en;
  logic [DW-1:0]   sat_l, sat_r;
  logic            clip_l, clip_r;

  assign rd     = (state_q == IDLE) && enable && !fifo.adc_fifo_empty;
  assign wr     = (state_q == WR) && !fifo.dac_fifo_full;
  assign mul_en = (state_q == MUL);

  chan_gain_sat u_left (
    .clk     (clk),
    .reset   (reset),
    .mul_en  (mul_en),
    .sample  (in_q[L_MSB:L_LSB]),
    .gain    (gl_q),
    .sat_out (sat_l),
    .clip    (clip_l)
  );

  chan_gain_sat u_right (
    .clk     (clk),
    .reset   (reset),
    .mul_en  (mul_en),
    .sample  (in_q[R_MSB:R_LSB]),
    .gain    (gr_q),
    .sat_out (sat_r),
    .clip    (clip_r)
  );

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    gl_d    = gl_q;
    gr_d    = gr_q;
    dac_d   = dac_q;
    case (state_q)
      IDLE: if (rd) begin
        in_d    = fifo.adc_fifo_out;
        gl_d    = gain_l;
        gr_d    = gain_r;
        state_d = MUL;
      end
      MUL:  state_d = SAT;
      SAT: begin
        dac_d   = bypass ? in_q : {sat_l, sat_r};
        state_d = WR;
      end
      WR:   if (wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      in_q    <= '0;
      gl_q    <= '0;
      gr_q    <= '0;
      dac_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      gl_q    <= gl_d;
      gr_q    <= gr_d;
      dac_q   <= dac_d;
    end
  end

`ifdef LOOPBACK_CLIP_CNT_EN
  logic        clip_pend_d, clip_pend_q;
  logic [15:0] clip_cnt_d, clip_cnt_q;

  // The clip decision is latched in SAT and only counted once the sample is written.
  always_comb begin
    clip_pend_d = clip_pend_q;
    clip_cnt_d  = clip_cnt_q;
    if (state_q == SAT) clip_pend_d = !bypass && (clip_l || clip_r);
    if (wr && clip_pend_q && (clip_cnt_q != 16'hFFFF)) clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clip_pend_q <= 1'b0;
      clip_cnt_q  <= '0;
    end else begin
      clip_pend_q <= clip_pend_d;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  assign clip_cnt = clip_cnt_q;
`else
  logic unused_clip;
  assign unused_clip = clip_l | clip_r;
  assign clip_cnt    = '0;
`endif

  assign fifo.rd_adc_fifo = rd;
  assign fifo.wr_dac_fifo = wr;
  assign fifo.dac_fifo_in = dac_q;
  assign busy             = (state_q != IDLE);
  assign sample_done_tick = wr;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_codec_loopback_gain.sv
// Scoreboard bench for codec_loopback_gain: an ADC FIFO model feeds words, a monitor
// predicts each output from an arithmetic reference model and checks DAC writes.
module tb_codec_loopback_gain;
  import codec_pkg::*;

`ifdef LOOPBACK_CLIP_CNT_EN
  localparam logic [15:0] SAT_CLIP_EXP = 16'd1;
`else
  localparam logic [15:0] SAT_CLIP_EXP = 16'd0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        enable, bypass;
  logic [7:0]  gain_l, gain_r;
  logic        busy, sample_done_tick;
  logic [15:0] clip_cnt;
  state_t      state_dbg;

  always #5 clk = ~clk;

  codec_loopback_gain_if fifo ();

  codec_loopback_gain dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .bypass           (bypass),
    .gain_l           (gain_l),
    .gain_r           (gain_r),
    .fifo             (fifo),
    .busy             (busy),
    .sample_done_tick (sample_done_tick),
    .clip_cnt         (clip_cnt),
    .state_dbg        (state_dbg)
  );

  // ---------------- bench state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  bit          clip_q[$];
  logic [31:0] adc_q[$];
  bit          pop_req = 0;
  int          cyc = 0, rd_cyc = 0, n_rd = 0, n_wr = 0;
  bit          stalled = 0;
  logic [31:0] last_wr = '0;
  logic [15:0] exp_clip = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: value * gain / 2^GFRAC rounded toward minus infinity, then clamped.
  function automatic logic [16:0] ref_chan(input logic [15:0] x, input logic [7:0] g);
    logic signed [15:0] xs;
    int p, s, div;
    bit c;
    xs  = x;
    div = 2 ** GFRAC;
    p   = int'(xs) * int'(g);
    s   = p / div;
    if (p < 0 && (p % div) != 0) s = s - 1;
    c = 0;
    if (s > 32767)       begin s = 32767;  c = 1; end
    else if (s < -32768) begin s = -32768; c = 1; end
    return {c, s[15:0]};
  endfunction

  // ---------------- ADC FIFO model ----------------
  always begin
    @(posedge clk);
    #1;
    if (pop_req) begin
      if (adc_q.size() > 0) void'(adc_q.pop_front());
      pop_req = 0;
    end
    #1;
    fifo.adc_fifo_empty = (adc_q.size() == 0);
    fifo.adc_fifo_out   = (adc_q.size() > 0) ? adc_q[0] : 32'h0;
  end

  always @(posedge clk) cyc++;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [16:0] l, r;
    logic [31:0] w;
    bit          c;
    if (reset) begin
      if (fifo.rd_adc_fifo) begin
        check("no_overlap", exp_q.size(), 0);
        w = fifo.adc_fifo_out;
        l = ref_chan(w[31:16], gain_l);
        r = ref_chan(w[15:0], gain_r);
        if (bypass) begin
          exp_q.push_back(w);
          clip_q.push_back(1'b0);
        end else begin
          exp_q.push_back({l[15:0], r[15:0]});
          clip_q.push_back(l[16] | r[16]);
        end
        rd_cyc  = cyc;
        stalled = 0;
        n_rd++;
        pop_req = 1;
      end
      if (fifo.dac_fifo_full) stalled = 1;
      if (fifo.wr_dac_fifo) begin
        check("wr_while_full", fifo.dac_fifo_full, 0);
        check("tick_on_wr", sample_done_tick, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          check("dac_word", fifo.dac_fifo_in, exp_q.pop_front());
          c = clip_q.pop_front();
          if (!stalled) check("latency", cyc - rd_cyc, 3);
          check("clip_cnt", clip_cnt, exp_clip);
`ifdef LOOPBACK_CLIP_CNT_EN
          if (c && exp_clip != 16'hFFFF) exp_clip++;
`endif
        end
        last_wr = fifo.dac_fifo_in;
        n_wr++;
      end else begin
        check("tick_idle", sample_done_tick, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int target, input string name);
    int k = 0;
    while (n_wr < target && k < 300) begin step(1); k++; end
    if (n_wr < target) check({name, "_timeout"}, n_wr, target);
  endtask

  task automatic wait_rd(input int target, input string name);
    int k = 0;
    while (n_rd < target && k < 100) begin step(1); k++; end
    if (n_rd < target) check({name, "_timeout"}, n_rd, target);
  endtask

  task automatic wait_state(input state_t s, input string name);
    int k = 0;
    while (state_dbg != s && k < 50) begin step(1); k++; end
    if (state_dbg != s) check({name, "_timeout"}, 32'(state_dbg), 32'(s));
  endtask

  task automatic run_one(input logic [31:0] word, input logic [7:0] gl, input logic [7:0] gr,
                         input logic byp, input logic [31:0] const_exp, input string name);
    int t;
    gain_l = gl; gain_r = gr; bypass = byp;
    t = n_wr + 1;
    adc_q.push_back(word);
    wait_wr(t, name);
    step(1);
    check(name, last_wr, const_exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},    fifo.rd_adc_fifo, 0);
    check({tag, "_wr"},    fifo.wr_dac_fifo, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_tick"},  sample_done_tick, 0);
    check({tag, "_dac"},   fifo.dac_fifo_in, 0);
    check({tag, "_clip"},  clip_cnt, 0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t, r0, w0;
    logic [31:0] hold, word;
    logic [31:0] edge_words[4];
    edge_words[0] = 32'h80008000; edge_words[1] = 32'h7FFF7FFF;
    edge_words[2] = 32'h00000000; edge_words[3] = 32'hFFFF0001;

    reset = 1'b0; enable = 1'b0; bypass = 1'b0; gain_l = 8'd64; gain_r = 8'd64;
    fifo.adc_fifo_empty = 1'b1; fifo.adc_fifo_out = '0; fifo.dac_fifo_full = 1'b0;
    step(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    enable = 1'b1;
    step(2);

    run_one(32'h1234EDCC, 8'd64,  8'd64,  1'b0, 32'h1234EDCC, "unity");
    run_one(32'h4000C000, 8'd128, 8'd128, 1'b0, 32'h7FFF8000, "saturate");
    check("sat_clip_cnt", clip_cnt, SAT_CLIP_EXP);
    run_one(32'h0003FFFD, 8'd32,  8'd32,  1'b0, 32'h0001FFFE, "floor");

    // Backpressure: hold WR for 10 cycles with a second word waiting upstream.
    gain_l = 8'd64; gain_r = 8'd64;
    fifo.dac_fifo_full = 1'b1;
    adc_q.push_back(32'h5A5AA5A5);
    adc_q.push_back(32'h01000100);
    wait_state(WR, "bp_reach_wr");
    hold = fifo.dac_fifo_in;
    r0 = n_rd; w0 = n_wr;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_stable", fifo.dac_fifo_in, hold);
      check("bp_no_wr", fifo.wr_dac_fifo, 0);
    end
    check("bp_no_rd", n_rd, r0);
    check("bp_no_write_cnt", n_wr, w0);
    fifo.dac_fifo_full = 1'b0;
    wait_wr(w0 + 1, "bp_release");
    step(1);
    check("bp_word", last_wr, 32'h5A5AA5A5);
    wait_wr(w0 + 2, "bp_second");
    step(1);
    check("bp_second_word", last_wr, 32'h01000100);

    // Empty FIFO: nothing is read.
    r0 = n_rd;
    step(8);
    check("empty_no_rd", n_rd, r0);
    check("empty_idle", busy, 0);

    // enable drops the cycle after a read: that sample still completes.
    adc_q.push_back(32'h00400040);
    adc_q.push_back(32'h00200020);
    wait_rd(r0 + 1, "en_rd");
    enable = 1'b0;
    wait_wr(n_wr + 1, "en_wr");
    step(1);
    check("en_word", last_wr, 32'h00400040);
    step(10);
    check("en_no_more_rd", n_rd, r0 + 1);
    check("en_fifo_left", adc_q.size(), 1);
    enable = 1'b1;
    wait_wr(n_wr + 1, "en_resume");

    // Gain change after capture only affects the next sample.
    r0 = n_rd;
    gain_l = 8'd64; gain_r = 8'd64;
    t = n_wr + 1;
    adc_q.push_back(32'h10002000);
    wait_rd(r0 + 1, "gchg_rd");
    gain_l = 8'd255; gain_r = 8'd0;
    wait_wr(t, "gchg_wr");
    step(1);
    check("gain_change", last_wr, 32'h10002000);

    run_one(32'hABCD1234, 8'd0, 8'd0, 1'b1, 32'hABCD1234, "bypass");
    bypass = 1'b0;

    // Reset while the sample sits in SAT: nothing must be written.
    gain_l = 8'd128; gain_r = 8'd128;
    adc_q.push_back(32'h4000C000);
    wait_state(SAT, "rst_reach_sat");
    reset = 1'b0;
    exp_q.delete();
    clip_q.delete();
    exp_clip = '0;
    #1;
    check_reset_outputs("mid_reset");
    w0 = n_wr;
    step(3);
    reset = 1'b1;
    step(6);
    check("mid_reset_no_wr", n_wr, w0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 150; i++) begin
      word   = (i % 10 == 0) ? edge_words[(i/10) % 4] : $urandom;
      gain_l = 8'($urandom_range(0, 255));
      gain_r = ($urandom_range(0, 3) == 0) ? 8'd64 : 8'($urandom_range(0, 255));
      bypass = ($urandom_range(0, 7) == 0);
      t = n_wr + 1;
      adc_q.push_back(word);
      for (int k = 0; k < 300 && n_wr < t; k++) begin
        fifo.dac_fifo_full = ($urandom_range(0, 3) == 0);
        step(1);
      end
      fifo.dac_fifo_full = 1'b0;
      if (n_wr < t) check("rand_timeout", n_wr, t);
    end
    step(4);

    check("exp_q_drained", exp_q.size(), 0);
    check("final_clip_cnt", clip_cnt, exp_clip);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_loopback_gain.md
Name: codec_loopback_gain

Overview:
- Loopback gain stage between the codec controller's ADC FIFO read side and DAC FIFO write side.
- Pops one stereo sample from the ADC FIFO and applies an independent per-channel gain with saturation.
- Pushes the result into the DAC FIFO.
- Sits directly downstream of the ADC FIFO and upstream of the DAC FIFO; it is the audio path of the line-in to headphone monitor.

Parameters:
- DW, 16: bits per channel; a sample word is 2*DW, with {left[2DW-1:DW], right[DW-1:0]}, signed two's complement.
- GW, 8: gain width, unsigned.
- GFRAC, 6: gain fractional bits; unity gain = 2^GFRAC = 64.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run loopback; 0 = stop taking new samples
- bypass  in  1  1 = pass samples unmodified (no gain, no clip count)
- gain_l  in  GW  left gain, unsigned Q(GW-GFRAC).GFRAC
- gain_r  in  GW  right gain, same format
- adc_fifo_empty  in  1  ADC FIFO empty
- adc_fifo_out  in  2*DW  ADC FIFO head word; valid whenever not empty (show-ahead)
- rd_adc_fifo  out  1  pop ADC FIFO (one-cycle pulse)
- dac_fifo_full  in  1  DAC FIFO full
- wr_dac_fifo  out  1  push DAC FIFO (one-cycle pulse)
- dac_fifo_in  out  2*DW  word pushed
- busy  out  1  state != IDLE
- sample_done_tick  out  1  one-cycle pulse coincident with wr_dac_fifo
- clip_cnt  out  16  saturated-sample counter (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; all registers cleared.
  - rd_adc_fifo, wr_dac_fifo, busy, sample_done_tick = 0.
  - dac_fifo_in = 0; clip_cnt = 0.
  - Reset mid-operation discards the in-flight sample; nothing is written.
- FSM states: IDLE, MUL, SAT, WR.
  - IDLE: rd_adc_fifo = enable & !adc_fifo_empty (combinational). On that edge, capture adc_fifo_out into in_reg and capture gain_l/gain_r into g_reg; go to MUL.
  - MUL: compute p_l = signed(in_l) * signed({1'b0,g_l}) (width DW+GW+1), same for right, into registers; go to SAT.
  - SAT: compute s = p >>> GFRAC (arithmetic shift, floor, no rounding). Clamp to [-2^(DW-1), 2^(DW-1)-1]. Load dac_fifo_in; go to WR.
    - If bypass (sampled in SAT), dac_fifo_in = in_reg unchanged.
  - WR: wr_dac_fifo = sample_done_tick = !dac_fifo_full. When not full, go to IDLE on that edge; while full, hold WR with dac_fifo_in stable.
- Latency: rd pulse at cycle N, write at cycle N+3 earliest. Minimum 4 cycles per sample; no overlap between samples.
- enable falling mid-sample: the current sample completes, including the write, and the block then idles. enable is only examined in IDLE.
- Gain changes mid-sample take effect on the next sample only.
- ADC FIFO empty in IDLE: stay in IDLE, no read.
- DAC FIFO full in WR: stall indefinitely. Upstream ADC FIFO overflow is not this block's concern.
- A clip event is either channel clamped in SAT with bypass=0. Counted once per sample even if both channels clip.

Optional Feature:
- Macro LOOPBACK_CLIP_CNT_EN.
- Defined: clip_cnt increments by 1 on the WR-exit edge of each clipped sample and saturates at 0xFFFF (no wrap).
- Undefined: no counter logic; clip_cnt is tied to 0.

Decomposition:
- Package codec_pkg holds:
  - DW, GW, GFRAC defaults.
  - The FSM state enum (IDLE, MUL, SAT, WR).
  - Channel slice constants (L_MSB, L_LSB, R_MSB, R_LSB).
  - SAT_MAX and SAT_MIN constants.
- Sub-module chan_gain_sat, instantiated twice (left, right), holds the multiply register, shift, clamp, and a clip flag output.
- The FSM, FIFO handshakes and clip counter stay in the top.

Test Plan:
- Unity gain: gain_l = gain_r = 64, ADC word 0x1234EDCC -> DAC word 0x1234EDCC; wr exactly 3 cycles after rd; clip_cnt stays 0.
- Saturation: gains = 128, L = 0x4000, R = 0xC000 -> 0x7FFF8000. clip_cnt = 1 (L clipped; R = -32768 exact, not a clip).
- Floor shift: gains = 32, L = 0x0003, R = 0xFFFD -> 0x0001FFFE.
- Backpressure: dac_fifo_full = 1 for 10 cycles while in WR -> no write, dac_fifo_in stable; one write on the cycle full drops; no second ADC read meanwhile.
- Empty / enable: adc_fifo_empty = 1 -> no rd. enable dropped the cycle after rd -> that sample is still written, then no further rd despite a non-empty FIFO.
- Reset mid-sample: assert reset in SAT -> outputs 0 immediately, no write. bypass = 1 with gain 0 and word 0xABCD1234 -> output 0xABCD1234.
